// File: rtl/alu_arb_pkg.sv
// Types shared by the ALU arbiter, its round-robin arbiter and the ALU.
package alu_arb_pkg;

    localparam int NREQ_MAX = 8;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/alu_types.sv
// Shared ALU command encoding. Code 3'd7 is deliberately left unassigned;
// the ALU answers it with data 0.
package alu_types;

    typedef enum logic [2:0] {
        CMD_ADD = 3'd0,
        CMD_SUB = 3'd1,
        CMD_INC = 3'd2,
        CMD_DEC = 3'd3,
        CMD_AND = 3'd4,
        CMD_OR  = 3'd5,
        CMD_NOT = 3'd6
    } cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Carry is bit 32 of the 33-bit ADD/SUB result
// (a SUB borrow reads as C=1); every other operation clears C. V is never set.
module alu
    import alu_types::*;
    import alu_arb_pkg::*;
(
    input  cmd_t        cmd_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] data_o,
    output flags_t      flags_o
);

    logic [32:0] wide;

    // Evaluate the selected operation; bit 32 only ever carries ADD/SUB carry.
    always_comb begin
        wide = 33'd0;
        case (cmd_i)
            CMD_ADD: wide = {1'b0, a_i} + {1'b0, b_i};
            CMD_SUB: wide = {1'b0, a_i} - {1'b0, b_i};
            CMD_INC: wide = {1'b0, a_i + 32'd1};
            CMD_DEC: wide = {1'b0, a_i - 32'd1};
            CMD_AND: wide = {1'b0, a_i & b_i};
            CMD_OR:  wide = {1'b0, a_i | b_i};
            CMD_NOT: wide = {1'b0, ~a_i};
            default: wide = 33'd0;
        endcase
    end

    assign data_o    = wide[31:0];
    assign flags_o.v = 1'b0;
    assign flags_o.c = wide[32];
    assign flags_o.n = wide[31];
    assign flags_o.z = (wide[31:0] == 32'd0);

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin arbiter: searches from last_grant+1 (mod N) and grants the
// first requester that is both requesting and unmasked. Grant is one-hot or 0.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  grant_o
);

    // Priority search starting just after the previous winner.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last_grant_i) + off) % N);
            if (!found && req_i[idx] && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between NREQ requesters (2..8). One request is
// accepted per cycle by round-robin; operands are registered (stage 1), the
// ALU runs on them and the result is registered (stage 2), so a response
// strobes rsp_valid two cycles after its accept.
//
// Optional build macro ALU_ARB_LOCK_EN adds grant locking:
//   state    | meaning
//   UNLOCKED | plain round-robin among all valid requesters
//   LOCKED   | only lock_owner_q may be granted until it sends lock=0
module alu_arbiter
    import alu_types::*;
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  cmd_t [NREQ-1:0]       req_cmd,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0]       req_lock,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_flags,
    output logic [31:0]           op_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] arb_mask;
    logic [IW-1:0]   gidx;
    logic            accept;

    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic            op_valid_q, op_valid_d;
    cmd_t            op_cmd_q, op_cmd_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic [IW-1:0]   op_idx_q, op_idx_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    flags_t          rsp_flags_q, rsp_flags_d;
    logic [31:0]     op_count_q, op_count_d;

    logic [31:0]     alu_data;
    flags_t          alu_flags;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .mask_i       (arb_mask),
        .grant_o      (grant)
    );

    alu u_alu (
        .cmd_i   (op_cmd_q),
        .a_i     (op_a_q),
        .b_i     (op_b_q),
        .data_o  (alu_data),
        .flags_o (alu_flags)
    );

    // Nothing is accepted while reset is asserted.
    assign req_ready = rst_n ? grant : '0;
    assign accept    = |req_ready;

    // Binary index of the granted requester.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = IW'(i);
        end
    end

`ifdef ALU_ARB_LOCK_EN
    lock_state_t   lock_state_q, lock_state_d;
    logic [IW-1:0] lock_owner_q, lock_owner_d;

    // Mask comes from registered lock state only, keeping the ready path loop-free.
    always_comb begin
        arb_mask = '1;
        if (lock_state_q == LOCKED) begin
            arb_mask               = '0;
            arb_mask[lock_owner_q] = 1'b1;
        end
    end

    // Lock FSM next state: enter on a locking accept, leave when the owner unlocks.
    always_comb begin
        lock_state_d = lock_state_q;
        lock_owner_d = lock_owner_q;
        case (lock_state_q)
            UNLOCKED: begin
                if (accept && req_lock[gidx]) begin
                    lock_state_d = LOCKED;
                    lock_owner_d = gidx;
                end
            end
            LOCKED: begin
                if (accept && !req_lock[gidx]) lock_state_d = UNLOCKED;
            end
            default: lock_state_d = UNLOCKED;
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state_q <= UNLOCKED;
            lock_owner_q <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign arb_mask    = '1;
`endif

    // Next-state for arbitration pointer, both pipeline stages and the counter.
    always_comb begin
        last_grant_d = accept ? gidx : last_grant_q;
        op_valid_d   = accept;
        op_cmd_d     = accept ? req_cmd[gidx] : op_cmd_q;
        op_a_d       = accept ? req_a[gidx]   : op_a_q;
        op_b_d       = accept ? req_b[gidx]   : op_b_q;
        op_idx_d     = accept ? gidx          : op_idx_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_flags_d  = rsp_flags_q;
        if (op_valid_q) begin
            rsp_valid_d[op_idx_q] = 1'b1;
            rsp_data_d            = alu_data;
            rsp_flags_d           = alu_flags;
        end
        op_count_d = op_count_q + {31'd0, accept};
    end

    // Pipeline and counter registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= IW'(NREQ - 1);
            op_valid_q   <= 1'b0;
            op_cmd_q     <= CMD_ADD;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_idx_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_flags_q  <= '0;
            op_count_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            op_valid_q   <= op_valid_d;
            op_cmd_q     <= op_cmd_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_idx_q     <= op_idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flags_q  <= rsp_flags_d;
            op_count_q   <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked against a transaction-level model.
module tb_alu_arbiter;
    import alu_types::*;

    localparam int NREQ = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready, req_lock, rsp_valid;
    cmd_t [NREQ-1:0]       req_cmd;
    logic [NREQ-1:0][31:0] req_a, req_b;
    logic [31:0]           rsp_data, op_count;
    logic [3:0]            rsp_flags;

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_a(req_a), .req_b(req_b), .req_lock(req_lock),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  oh;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_lg = NREQ - 1;
    logic [31:0] m_count = 0;
    bit          m_locked = 0;
    int          m_owner = 0;
    exp_t        mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference ALU: {flags V,C,N,Z, data} from plain arithmetic.
    function automatic logic [35:0] ref_alu(input cmd_t c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic        cy;
        longint      sum;
        d  = 0;
        cy = 0;
        case (c)
            CMD_ADD: begin sum = longint'(a) + longint'(b); d = a + b; cy = (sum > 64'hFFFF_FFFF); end
            CMD_SUB: begin d = a - b; cy = (a < b); end
            CMD_INC: d = a + 1;
            CMD_DEC: d = a - 1;
            CMD_AND: d = a & b;
            CMD_OR:  d = a | b;
            CMD_NOT: d = ~a;
            default: d = 0;
        endcase
        return {1'b0, cy, d[31], (d == 0), d};
    endfunction

    function automatic logic [NREQ-1:0] exp_grant();
        logic [NREQ-1:0] g;
        g = '0;
        if (rst_n) begin
            for (int off = 1; off <= NREQ; off++) begin
                int idx;
                idx = (m_lg + off) % NREQ;
                if (g == 0 && req_valid[idx] && (!m_locked || idx == m_owner)) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // One clock cycle: check ready, advance model on the edge, check outputs.
    task automatic step();
        logic [NREQ-1:0] g;
        logic [35:0]     r;
        exp_t            e;
        int              gi;
        #1;
        g = exp_grant();
        chk("req_ready", 32'(req_ready), 32'(g));
        @(posedge clk);
        if (!rst_n) begin
            m_lg = NREQ - 1; m_count = 0; m_locked = 0; mq.delete();
        end else if (g != 0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (g[i]) gi = i;
            r = ref_alu(req_cmd[gi], req_a[gi], req_b[gi]);
            e.due = cyc + 2; e.oh = g; e.data = r[31:0]; e.flags = r[35:32];
            mq.push_back(e);
            m_lg = gi;
            m_count = m_count + 1;
`ifdef ALU_ARB_LOCK_EN
            if (!m_locked && req_lock[gi]) begin m_locked = 1; m_owner = gi; end
            else if (m_locked && !req_lock[gi]) m_locked = 0;
`endif
        end
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            e = mq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.oh));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 0);
        end
        chk("op_count", op_count, m_count);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = '0;
        req_lock  = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); step(); rst_n = 1'b1;
    endtask

    logic [31:0] edge_vals [5];
    logic [3:0]  oh;

    initial begin
        edge_vals[0] = 32'h0; edge_vals[1] = 32'h1; edge_vals[2] = 32'hFFFF_FFFF;
        edge_vals[3] = 32'h8000_0000; edge_vals[4] = 32'h7FFF_FFFF;
        rst_n = 1'b0;
        idle();
        for (int i = 0; i < NREQ; i++) begin req_cmd[i] = CMD_ADD; req_a[i] = 0; req_b[i] = 0; end
        @(negedge clk);
        step(); step();
        rst_n = 1'b1;

        // Requester 0 ADD 5+7: result two cycles after accept.
        req_valid = 4'b0001; req_cmd[0] = CMD_ADD; req_a[0] = 5; req_b[0] = 7;
        #1 chk("add_ready", 32'(req_ready), 32'h1);
        step(); idle(); step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_rsp_data", rsp_data, 12);
        chk("add_rsp_flags", 32'(rsp_flags), 0);

        // All four valid with INC of A=i: grants and responses 0,1,2,3,0,1.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                req_valid = 4'b1111;
                for (int i = 0; i < NREQ; i++) begin req_cmd[i] = CMD_INC; req_a[i] = i; end
                oh = 4'b0001 << (k % 4);
                #1 chk("inc_grant", 32'(req_ready), 32'(oh));
            end else idle();
            step();
            if (k >= 1) begin
                oh = 4'b0001 << ((k - 1) % 4);
                chk("inc_rsp_valid", 32'(rsp_valid), 32'(oh));
                chk("inc_rsp_data", rsp_data, 32'((k - 1) % 4 + 1));
            end
            if (k == 5) chk("inc_op_count", op_count, 6);
        end

        // Borrow and carry-out edge cases on requester 1.
        req_valid = 4'b0010; req_cmd[1] = CMD_SUB; req_a[1] = 0; req_b[1] = 1;
        step(); idle(); step();
        chk("sub_data", rsp_data, 32'hFFFF_FFFF);
        chk("sub_flags", 32'(rsp_flags), 32'h6);
        req_valid = 4'b0010; req_cmd[1] = CMD_ADD; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 1;
        step(); idle(); step();
        chk("addc_data", rsp_data, 0);
        chk("addc_flags", 32'(rsp_flags), 32'h5);

        // Reset one cycle after an accept discards it; outputs all 0 in reset.
        req_valid = 4'b0001; req_cmd[0] = CMD_OR; req_a[0] = 32'h0F0; req_b[0] = 32'h00F;
        step();
        rst_n = 1'b0; req_valid = 4'b1111;
        #1 chk("rst_ready", 32'(req_ready), 0);
        step();
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_flags", 32'(rsp_flags), 0);
        chk("rst_op_count", op_count, 0);
        rst_n = 1'b1;
        #1 chk("post_rst_grant", 32'(req_ready), 32'h1);
        step(); idle(); step(); step();

        // Lock sequence from requester 2 while 0,1,3 are valid.
        do_reset();
`ifdef ALU_ARB_LOCK_EN
        req_valid = 4'b0011; step(); step();
        req_valid = 4'b1111; req_lock = 4'b0100;
        #1 chk("lock_g0", 32'(req_ready), 32'h4);
        step();
        #1 chk("lock_g1", 32'(req_ready), 32'h4);
        step();
        req_lock = 4'b0000;
        #1 chk("lock_g2", 32'(req_ready), 32'h4);
        step();
        #1 chk("lock_resume", 32'(req_ready), 32'h8);
        step();
`else
        req_valid = 4'b1111; req_lock = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            oh = 4'b0001 << k;
            #1 chk("nolock_grant", 32'(req_ready), 32'(oh));
            step();
        end
`endif
        idle(); step(); step();

        // op_count wrap: preload all-ones, next accept gives 0.
        force dut.op_count_q = 32'hFFFF_FFFF;
        #1 release dut.op_count_q;
        m_count = 32'hFFFF_FFFF;
        req_valid = 4'b0001; req_cmd[0] = CMD_AND;
        step();
        chk("wrap_op_count", op_count, 0);
        idle(); step(); step();

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            req_valid = 4'($urandom_range(0, 15));
            req_lock  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                req_cmd[i] = cmd_t'(3'($urandom_range(0, 7)));
                req_a[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom();
                req_b[i] = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom();
            end
            step();
        end
        rst_n = 1'b1; idle(); step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
